// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit direction counters
//
// Purpose: predicts next-PC redirects for the fetch PC in the IF stage. The
// table is trained by resolved branches and jumps coming back from EX.
// Lookup is purely combinational from the registered table state. Updates
// commit on the next rising clock edge.
//
// Ports:
//   i_clk            clock
//   i_rst            asynchronous active-high reset (clears valid bits only)
//   i_fetch_pc       PC being fetched this cycle
//   o_predict_taken  redirect predicted for i_fetch_pc
//   o_predict_target predicted target (zero unless o_predict_taken)
//   i_update_valid   a resolved control-flow instruction retires this cycle
//   i_update_pc      PC of the resolved instruction
//   i_update_taken   resolved direction
//   i_update_target  resolved target address
//   i_update_is_jump JAL/JALR (unconditional)
//   i_flush          invalidate the whole table at the next edge
module branch_target_buffer #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_fetch_pc,
  output logic            o_predict_taken,
  output logic [XLEN-1:0] o_predict_target,
  input  logic            i_update_valid,
  input  logic [XLEN-1:0] i_update_pc,
  input  logic            i_update_taken,
  input  logic [XLEN-1:0] i_update_target,
  input  logic            i_update_is_jump,
  input  logic            i_flush
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = XLEN - 1 - IDX_BITS;

  // Table storage. Only the valid bits are reset; the other fields are
  // meaningless while their entry is invalid.
  logic [ENTRIES-1:0] valid;
  logic [TAG_BITS-1:0] tag_mem [ENTRIES];
  logic [XLEN-1:1]     tgt_mem [ENTRIES];
  logic [1:0]          ctr_mem [ENTRIES];

  // Lookup side. Index starts at bit 1 so compressed (2-byte) instructions
  // map to distinct entries.
  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic                fetch_hit;

  assign fetch_idx = i_fetch_pc[IDX_BITS:1];
  assign fetch_tag = i_fetch_pc[XLEN-1:IDX_BITS+1];
  assign fetch_hit = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

  always_comb begin
    o_predict_taken  = 1'b0;
    o_predict_target = '0;
    if (fetch_hit && ctr_mem[fetch_idx][1]) begin
      o_predict_taken  = 1'b1;
      o_predict_target = {tgt_mem[fetch_idx], 1'b0};
    end
  end

  // Update side.
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic                upd_taken;    // jumps always count as taken
  logic                upd_alloc;    // write tag/target and set valid
  logic                upd_ctr_we;   // counter changes this cycle
  logic [1:0]          upd_ctr_next;

  assign upd_idx   = i_update_pc[IDX_BITS:1];
  assign upd_tag   = i_update_pc[XLEN-1:IDX_BITS+1];
  assign upd_hit   = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign upd_taken = i_update_is_jump || i_update_taken;

  always_comb begin
    upd_alloc    = 1'b0;
    upd_ctr_we   = 1'b0;
    upd_ctr_next = ctr_mem[upd_idx];
    // Flush takes priority: a same-cycle update is dropped.
    if (i_update_valid && !i_flush) begin
      if (i_update_is_jump) begin
        upd_alloc    = 1'b1;
        upd_ctr_we   = 1'b1;
        upd_ctr_next = 2'b11;
      end else if (upd_hit) begin
        upd_ctr_we = 1'b1;
        if (upd_taken) begin
          // Hit and taken also refreshes the target (indirect targets move).
          upd_alloc = 1'b1;
          if (ctr_mem[upd_idx] != 2'b11) begin
            upd_ctr_next = ctr_mem[upd_idx] + 2'd1;
          end
        end else if (ctr_mem[upd_idx] != 2'b00) begin
          upd_ctr_next = ctr_mem[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        upd_alloc    = 1'b1;
        upd_ctr_we   = 1'b1;
        upd_ctr_next = 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid <= '0;
    end else if (i_flush) begin
      valid <= '0;
    end else if (upd_alloc) begin
      valid[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (upd_alloc) begin
        tag_mem[upd_idx] <= upd_tag;
        tgt_mem[upd_idx] <= i_update_target[XLEN-1:1];
      end
      if (upd_ctr_we) begin
        ctr_mem[upd_idx] <= upd_ctr_next;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_is_jump;
  logic        flush;

  int total = 0;
  int bad   = 0;

  branch_target_buffer #(.XLEN(32), .ENTRIES(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fetch_pc       (fetch_pc),
    .o_predict_taken  (predict_taken),
    .o_predict_target (predict_target),
    .i_update_valid   (update_valid),
    .i_update_pc      (update_pc),
    .i_update_taken   (update_taken),
    .i_update_target  (update_target),
    .i_update_is_jump (update_is_jump),
    .i_flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_taken, input logic [31:0] exp_target);
    fetch_pc = pc;
    #1;
    check({tag, ".taken"}, {31'd0, predict_taken}, {31'd0, exp_taken});
    check({tag, ".target"}, predict_target, exp_target);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] target, input logic jump);
    update_valid   = 1'b1;
    update_pc      = pc;
    update_taken   = taken;
    update_target  = target;
    update_is_jump = jump;
    @(posedge clk);
    #1;
    update_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    fetch_pc       = 32'h0000_1000;
    update_valid   = 1'b0;
    update_pc      = '0;
    update_taken   = 1'b0;
    update_target  = '0;
    update_is_jump = 1'b0;
    flush          = 1'b0;

    look("in_reset", 32'h1000, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    look("after_reset", 32'h1000, 1'b0, 32'h0);

    // allocate weakly taken, then walk the counter down and back up
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    look("alloc", 32'h1000, 1'b1, 32'h2000);
    upd(32'h1000, 1'b0, 32'h0, 1'b0);
    look("ctr1", 32'h1000, 1'b0, 32'h0);
    upd(32'h1000, 1'b0, 32'h0, 1'b0);
    look("ctr0", 32'h1000, 1'b0, 32'h0);
    upd(32'h1000, 1'b0, 32'h0, 1'b0);
    look("ctr0_sat", 32'h1000, 1'b0, 32'h0);
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    look("ctr0_to1", 32'h1000, 1'b0, 32'h0);
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    look("ctr2_again", 32'h1000, 1'b1, 32'h2000);
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    upd(32'h1000, 1'b0, 32'h0, 1'b0);
    look("ctr3_sat_dec", 32'h1000, 1'b1, 32'h2000);
    upd(32'h1000, 1'b0, 32'h0, 1'b0);
    look("ctr1_from3", 32'h1000, 1'b0, 32'h0);

    // alias: same index, different tag replaces the entry
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    upd(32'h1040, 1'b1, 32'h3000, 1'b0);
    look("alias_old", 32'h1000, 1'b0, 32'h0);
    look("alias_new", 32'h1040, 1'b1, 32'h3000);

    // JALR with odd target and taken=0
    upd(32'h4000, 1'b0, 32'h5001, 1'b1);
    look("jalr", 32'h4000, 1'b1, 32'h5000);
    upd(32'h4000, 1'b0, 32'h0, 1'b0);
    look("jalr_dec", 32'h4000, 1'b1, 32'h5000);
    upd(32'h4000, 1'b1, 32'h6000, 1'b0);
    look("retarget", 32'h4000, 1'b1, 32'h6000);

    // miss and not taken leaves the resident entry alone
    upd(32'h1100, 1'b0, 32'h7000, 1'b0);
    look("miss_nt_other", 32'h1100, 1'b0, 32'h0);
    look("miss_nt_keep", 32'h4000, 1'b1, 32'h6000);

    // update_valid low ignores X update inputs
    update_pc      = 'x;
    update_taken   = 1'b1;
    update_target  = 'x;
    update_is_jump = 1'bx;
    @(posedge clk);
    #1;
    look("idle_x", 32'h4000, 1'b1, 32'h6000);

    // same-cycle lookup and update to one index sees old contents
    update_valid   = 1'b1;
    update_pc      = 32'h1010;
    update_taken   = 1'b1;
    update_target  = 32'h8000;
    update_is_jump = 1'b0;
    look("bypass_old", 32'h1010, 1'b0, 32'h0);
    @(posedge clk);
    #1 update_valid = 1'b0;
    look("bypass_new", 32'h1010, 1'b1, 32'h8000);

    // flush wins over a simultaneous update; lookup still sees old contents
    flush          = 1'b1;
    update_valid   = 1'b1;
    update_pc      = 32'h1020;
    update_taken   = 1'b1;
    update_target  = 32'h9000;
    update_is_jump = 1'b0;
    look("flush_cycle", 32'h4000, 1'b1, 32'h6000);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    update_valid = 1'b0;
    look("flush_4000", 32'h4000, 1'b0, 32'h0);
    look("flush_1010", 32'h1010, 1'b0, 32'h0);
    look("flush_upd", 32'h1020, 1'b0, 32'h0);

    // asynchronous reset mid-cycle with an update in flight
    upd(32'h1030, 1'b1, 32'hA000, 1'b0);
    look("pre_rst", 32'h1030, 1'b1, 32'hA000);
    update_valid   = 1'b1;
    update_pc      = 32'h1034;
    update_taken   = 1'b1;
    update_target  = 32'hB000;
    update_is_jump = 1'b1;
    #2 rst = 1'b1;
    look("async_rst", 32'h1030, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    update_valid = 1'b0;
    look("rst_lost_upd", 32'h1034, 1'b0, 32'h0);
    look("rst_1030", 32'h1030, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
